// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator car panel and car controller.
package elevator_pkg;

    localparam int unsigned DEFAULT_NUM_FLOORS      = 8;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } panel_state_t;

    // Floor index width; never narrower than one bit.
    function automatic int unsigned floor_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_car_panel_button_debouncer.sv
// Two-flop synchroniser plus stability counter for one car button; flags a
// single-cycle rise when the debounced level goes high.
module button_debouncer
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_expire;

    assign w_differs = r_sync2 ^ r_level;
    // The final differing sample is the DEBOUNCE_CYCLES-th one.
    assign w_expire  = w_differs && ((32'(r_cnt) + 32'd1) == 32'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_expire && !r_level;
            if (!w_differs || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_expire) begin
                r_level <= ~r_level;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/elevator_car_panel.sv
// Car-interior floor-request panel: debounced buttons latch sticky requests
// that drive the lamps and are issued round-robin to the car controller.
module elevator_car_panel
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = DEFAULT_NUM_FLOORS,
    parameter int unsigned FLOOR_W         = floor_width(NUM_FLOORS),
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_FLOORS-1:0]                buttons,
    input  logic [FLOOR_W-1:0]                   current_floor,
    input  logic                                 door_open,
    output logic                                 req_valid,
    output logic [FLOOR_W-1:0]                   req_floor,
    input  logic                                 req_ready,
    input  logic                                 served_valid,
    input  logic [FLOOR_W-1:0]                   served_floor,
    output logic [NUM_FLOORS-1:0]                lamps,
    output logic [$clog2(NUM_FLOORS+1)-1:0]      pending_count
);

    localparam int unsigned PCNT_W = $clog2(NUM_FLOORS + 1);

    panel_state_t          r_state;
    panel_state_t          w_state_next;

    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] r_issued;
    logic                  r_req_valid;
    logic [FLOOR_W-1:0]    r_req_floor;
    logic [FLOOR_W-1:0]    r_rr_ptr;
    logic [PCNT_W-1:0]     r_pending_count;

    logic [NUM_FLOORS-1:0] w_level;
    logic [NUM_FLOORS-1:0] w_rise;
    logic                  w_levels_unused;

    logic [NUM_FLOORS-1:0] w_door_mask;
    logic [NUM_FLOORS-1:0] w_serve_mask;
    logic [NUM_FLOORS-1:0] w_offer_mask;
    logic [NUM_FLOORS-1:0] w_xfer_mask;
    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic [NUM_FLOORS-1:0] w_issued_next;
    logic [NUM_FLOORS-1:0] w_cand;
    logic [PCNT_W-1:0]     w_count_next;

    logic                  w_xfer;
    logic                  w_withdraw;

    logic                  w_low_found;
    logic                  w_high_found;
    logic [FLOOR_W-1:0]    w_low_floor;
    logic [FLOOR_W-1:0]    w_high_floor;
    logic                  w_sel_found;
    logic [FLOOR_W-1:0]    w_sel_floor;

    logic                  w_req_valid_next;
    logic [FLOOR_W-1:0]    w_req_floor_next;
    logic [FLOOR_W-1:0]    w_rr_ptr_next;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_button
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons[g]),
            .level (w_level[g]),
            .rise  (w_rise[g])
        );
    end

    // Only the press edge matters here; the held level has no consumer.
    assign w_levels_unused = ^w_level;

    // Per-floor decode of the floor-indexed inputs; out-of-range indices match nothing.
    always_comb begin
        w_door_mask  = '0;
        w_serve_mask = '0;
        w_offer_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_door_mask[i]  = door_open && (current_floor == FLOOR_W'(i));
            w_serve_mask[i] = served_valid && (served_floor == FLOOR_W'(i));
            w_offer_mask[i] = (r_req_floor == FLOOR_W'(i));
        end
    end

    assign w_xfer         = r_req_valid && req_ready;
    assign w_xfer_mask    = w_offer_mask & {NUM_FLOORS{w_xfer}};
    assign w_withdraw     = |(w_serve_mask & w_offer_mask);
    assign w_press        = w_rise & ~w_door_mask;
    // A press landing with a serve of the same floor wins and re-arms it.
    assign w_pending_next = (r_pending & ~w_serve_mask) | w_press;
    assign w_issued_next  = (r_issued | w_xfer_mask) & ~w_serve_mask;
    // Floors being served this cycle are not offered, so no stale offer appears.
    assign w_cand         = r_pending & ~r_issued & ~w_serve_mask;

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_count_next = w_count_next + PCNT_W'(w_pending_next[i]);
        end
    end

    // Downward scan keeps the lowest candidate overall and the lowest at or above rr_ptr.
    always_comb begin
        w_low_found  = 1'b0;
        w_low_floor  = '0;
        w_high_found = 1'b0;
        w_high_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_low_found = 1'b1;
                w_low_floor = FLOOR_W'(i);
                if (FLOOR_W'(i) >= r_rr_ptr) begin
                    w_high_found = 1'b1;
                    w_high_floor = FLOOR_W'(i);
                end
            end
        end
    end

    assign w_sel_found = w_low_found;
    assign w_sel_floor = w_high_found ? w_high_floor : w_low_floor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_req_valid_next = r_req_valid;
        w_req_floor_next = r_req_floor;
        w_rr_ptr_next    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_sel_found) begin
                    w_state_next     = OFFER;
                    w_req_valid_next = 1'b1;
                    w_req_floor_next = w_sel_floor;
                end
            end
            OFFER: begin
                if (w_xfer) begin
                    w_state_next     = IDLE;
                    w_req_valid_next = 1'b0;
                    w_rr_ptr_next    = (r_req_floor == FLOOR_W'(NUM_FLOORS - 1))
                                       ? '0 : r_req_floor + FLOOR_W'(1);
                end else if (w_withdraw) begin
                    w_state_next     = IDLE;
                    w_req_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_req_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending       <= '0;
            r_issued        <= '0;
            r_req_valid     <= 1'b0;
            r_req_floor     <= '0;
            r_rr_ptr        <= '0;
            r_pending_count <= '0;
        end else begin
            r_pending       <= w_pending_next;
            r_issued        <= w_issued_next;
            r_req_valid     <= w_req_valid_next;
            r_req_floor     <= w_req_floor_next;
            r_rr_ptr        <= w_rr_ptr_next;
            r_pending_count <= w_count_next;
        end
    end

    assign req_valid     = r_req_valid;
    assign req_floor     = r_req_floor;
    assign lamps         = r_pending;
    assign pending_count = r_pending_count;

endmodule
